// File: rtl/reduce_exec_pkg.sv
// rtl/reduce_exec_pkg.sv - shared state encoding, rule numbers and operand-count helper
// for the shift/reduce executor.
package reduce_exec_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  localparam logic [15:0] RULE_OUT     = 16'd3;
  localparam logic [15:0] RULE_STORE_A = 16'd4;
  localparam logic [15:0] RULE_IF      = 16'd7;
  localparam logic [15:0] RULE_ADD     = 16'd8;
  localparam logic [15:0] RULE_SUB     = 16'd9;
  localparam logic [15:0] RULE_COPY_LO = 16'd10;
  localparam logic [15:0] RULE_COPY_HI = 16'd12;
  localparam logic [15:0] RULE_LOAD_A  = 16'd13;
  localparam logic [15:0] RULE_LAST    = 16'd15;

  // Operands popped by each rule; unknown rules pop nothing.
  function automatic logic [1:0] popcount(input logic [15:0] rule);
    if (rule > RULE_LAST) return 2'd0;
    case (rule[3:0])
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12: return 2'd1;
      4'd8, 4'd9: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/reduce_exec_if.sv
// rtl/reduce_exec_if.sv - token handshake and result bus between the parser and the executor.
interface reduce_exec_if #(
  parameter int DATA_W = 8
);
  logic              i_valid;
  logic [15:0]       i_shift;
  logic [15:0]       i_reduce;
  logic              receive;
  logic [DATA_W-1:0] o_result;
  logic              o_result_valid;
  logic              o_busy;
  logic              o_error;

  modport master (
    output i_valid, i_shift, i_reduce,
    input  receive, o_result, o_result_valid, o_busy, o_error
  );

  modport slave (
    input  i_valid, i_shift, i_reduce,
    output receive, o_result, o_result_valid, o_busy, o_error
  );
endinterface

// File: rtl/reduce_exec_lifo_param.sv
// rtl/reduce_exec_lifo_param.sv - value stack with combinational top, synchronous push/pop.
// Push when full and pop when empty are ignored; the caller flags the error.
module lifo_param #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [DATA_W-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W:0]    count_q, count_d;

  assign full  = (count_q == (PTR_W+1)'(STACK_DEPTH));
  assign empty = (count_q == '0);
  // Empty stack reads as zero so an underflowing reduce still has operands.
  assign top   = empty ? '0 : mem_q[count_q[PTR_W-1:0] - 1'b1];

  always_comb begin
    count_d = count_q;
    if (push && !full) count_d = count_q + 1'b1;
    else if (pop && !empty) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[count_q[PTR_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/reduce_exec_core.sv
// rtl/reduce_exec_core.sv - stack-machine executor for the LR parser's shift/reduce stream.
// Shifts push literals in S_IDLE; reduces pop operands one per cycle, then execute in S_EXEC.
module reduce_exec_core #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 1024,
  parameter int NUM_VARS    = 3,
  parameter int MAX_POP     = 2
) (
  input logic           clk,
  input logic           rst_n,
  reduce_exec_if.slave  bus
);
  import reduce_exec_pkg::*;

  state_t            state_q, state_d;
  logic [15:0]       rule_q, rule_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] opnd_q [MAX_POP];
  logic [DATA_W-1:0] opnd_d [MAX_POP];
  logic [DATA_W-1:0] var_q [NUM_VARS];
  logic [DATA_W-1:0] var_d [NUM_VARS];
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              error_q, error_d;

  logic              push, pop, receive, full, empty;
  logic [DATA_W-1:0] push_data, top;

  lifo_param #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) u_lifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
    .top(top), .full(full), .empty(empty)
  );

  always_comb begin
    state_d        = state_q;
    rule_d         = rule_q;
    cnt_d          = cnt_q;
    opnd_d         = opnd_q;
    var_d          = var_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = error_q;
    push           = 1'b0;
    pop            = 1'b0;
    push_data      = '0;
    receive        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_shift != 16'd0) begin
            receive = 1'b1;
            if (bus.i_shift[15:8] == 8'd0) begin
              push      = 1'b1;
              push_data = bus.i_shift[DATA_W-1:0];
            end
          end else begin
            rule_d  = bus.i_reduce;
            cnt_d   = popcount(bus.i_reduce);
            state_d = (cnt_d == 2'd0) ? S_EXEC : S_POP;
          end
        end
      end
      S_POP: begin
        pop = 1'b1;
        if (empty) error_d = 1'b1;
        for (int i = 0; i < MAX_POP; i++) begin
          if (cnt_q == 2'(i + 1)) opnd_d[i] = top;
        end
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = S_EXEC;
      end
      S_EXEC: begin
        receive = 1'b1;
        state_d = S_IDLE;
        if (rule_q > RULE_LAST) begin
          error_d = 1'b1;
        end else if (rule_q == RULE_OUT) begin
          result_d       = opnd_q[0];
          result_valid_d = 1'b1;
        end else if (rule_q == RULE_ADD) begin
          push      = 1'b1;
          push_data = opnd_q[0] + opnd_q[1];
        end else if (rule_q == RULE_SUB) begin
          push      = 1'b1;
          push_data = opnd_q[0] - opnd_q[1];
        end else if (rule_q >= RULE_COPY_LO && rule_q <= RULE_COPY_HI) begin
          push      = 1'b1;
          push_data = opnd_q[0];
        end
        for (int i = 0; i < NUM_VARS; i++) begin
          if (rule_q == RULE_STORE_A + 16'(i)) var_d[i] = opnd_q[0];
          if (rule_q == RULE_LOAD_A + 16'(i)) begin
            push      = 1'b1;
            push_data = var_q[i];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Shared overflow check covers both literal shifts and result pushes.
    if (push && full) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rule_q         <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < MAX_POP; i++) opnd_q[i] <= '0;
      for (int i = 0; i < NUM_VARS; i++) var_q[i] <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rule_q         <= rule_d;
      cnt_q          <= cnt_d;
      opnd_q         <= opnd_d;
      var_q          <= var_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  assign bus.receive        = receive;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_error        = error_q;
endmodule

// File: tb/tb_reduce_exec_core.sv
// tb/tb_reduce_exec_core.sv - directed and randomized checks of reduce_exec_core
// against a queue-based stack-machine model.
module tb_reduce_exec_core;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reduce_exec_if #(.DATA_W(DATA_W)) bus ();

  reduce_exec_core #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH), .NUM_VARS(3), .MAX_POP(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int unsigned stk[$];
  int unsigned vars[3];
  int unsigned m_result;
  bit          m_err;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_npop(input int unsigned r);
    if (r inside {[3:7], [10:12]}) return 1;
    if (r inside {8, 9}) return 2;
    return 0;
  endfunction

  task automatic m_push(input int unsigned v);
    if (stk.size() >= DEPTH) m_err = 1'b1;
    else stk.push_back(v % 256);
  endtask

  task automatic m_pop(output int unsigned v);
    if (stk.size() == 0) begin
      m_err = 1'b1;
      v = 0;
    end else v = stk.pop_back();
  endtask

  task automatic m_reset();
    stk.delete();
    foreach (vars[i]) vars[i] = 0;
    m_result = 0;
    m_err = 1'b0;
  endtask

  task automatic m_apply(input logic [15:0] sh, input logic [15:0] rd, output bit pulse);
    int unsigned a, b, r, n;
    pulse = 1'b0;
    a = 0;
    b = 0;
    r = rd;
    if (sh != 0) begin
      if (sh[15:8] == 0) m_push(sh[7:0]);
    end else begin
      n = m_npop(r);
      if (n == 2) begin
        m_pop(b);
        m_pop(a);
      end else if (n == 1) m_pop(a);
      if (r == 3) begin
        m_result = a;
        pulse = 1'b1;
      end
      else if (r inside {[4:6]}) vars[r-4] = a;
      else if (r == 8) m_push(a + b);
      else if (r == 9) m_push(a + 256 - b);
      else if (r inside {[10:12]}) m_push(a);
      else if (r inside {[13:15]}) m_push(vars[r-13]);
      else if (r >= 16) m_err = 1'b1;
    end
  endtask

  task automatic issue(input logic [15:0] sh, input logic [15:0] rd, output int cyc, output logic pulse);
    cyc = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_shift = sh;
    bus.i_reduce = rd;
    #1;
    while (!bus.receive && cyc < 8) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    pulse = bus.o_result_valid;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_shift = '0;
    bus.i_reduce = '0;
  endtask

  task automatic step(input logic [15:0] sh, input logic [15:0] rd);
    int cyc, exp_cyc;
    logic pulse;
    bit exp_pulse;
    exp_cyc = (sh != 0) ? 0 : int'(m_npop(rd)) + 1;
    m_apply(sh, rd, exp_pulse);
    issue(sh, rd, cyc, pulse);
    check("latency", cyc, exp_cyc);
    check("result_valid", pulse, exp_pulse);
    check("o_result", bus.o_result, m_result);
    check("o_error", bus.o_error, m_err);
    check("o_busy", bus.o_busy, 1'b0);
    check("stack_empty", dut.u_lifo.empty, stk.size() == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_shift = '0;
    bus.i_reduce = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    int sel;
    bus.i_valid = 1'b0;
    bus.i_shift = '0;
    bus.i_reduce = '0;
    m_reset();
    #2;
    check("rst_result", bus.o_result, 8'h00);
    check("rst_result_valid", bus.o_result_valid, 1'b0);
    check("rst_error", bus.o_error, 1'b0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_empty", dut.u_lifo.empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    step(16'd5, 16'd0);
    step(16'd3, 16'd0);
    step(16'd0, 16'd11);
    step(16'd0, 16'd11);
    step(16'd0, 16'd8);
    step(16'd0, 16'd3);
    check("stream_result", bus.o_result, 8'd8);
    check("stream_empty", dut.u_lifo.empty, 1'b1);
    @(negedge clk);
    check("pulse_one_cycle", bus.o_result_valid, 1'b0);

    do_reset();
    step(16'd2, 16'd0);
    step(16'd5, 16'd0);
    step(16'd0, 16'd9);
    step(16'd0, 16'd3);
    check("sub_wrap", bus.o_result, 8'hFD);

    do_reset();
    step(16'd7, 16'd0);
    step(16'd0, 16'd4);
    step(16'd0, 16'd13);
    step(16'd0, 16'd3);
    check("store_load", bus.o_result, 8'd7);
    check("store_load_err", bus.o_error, 1'b0);

    do_reset();
    step(16'd0, 16'd8);
    check("underflow_err", bus.o_error, 1'b1);
    step(16'd0, 16'd3);
    check("underflow_push0", bus.o_result, 8'd0);
    step(16'h0105, 16'd0);
    step(16'd0, 16'd20);
    check("bad_rule_err", bus.o_error, 1'b1);

    do_reset();
    for (int i = 1; i <= 5; i++) step(16'(i * 16), 16'd0);
    check("overflow_err", bus.o_error, 1'b1);
    step(16'd0, 16'd3);
    check("overflow_top", bus.o_result, 8'h40);

    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_shift = '0;
    bus.i_reduce = 16'd8;
    @(posedge clk);
    #1;
    check("mid_busy", bus.o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.o_busy, 1'b0);
    check("arst_error", bus.o_error, 1'b0);
    check("arst_result", bus.o_result, 8'h00);
    check("arst_empty", dut.u_lifo.empty, 1'b1);
    m_reset();
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_reduce = '0;
    rst_n = 1'b1;
    step(16'd9, 16'd0);
    step(16'd0, 16'd3);
    check("after_reset", bus.o_result, 8'd9);

    do_reset();
    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) step(16'($urandom_range(1, 255)), 16'd0);
      else if (sel == 5) step({8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))}, 16'd0);
      else step(16'd0, 16'($urandom_range(0, 17)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
